perf_event_counter_bank: RTL and testbench

- Downstream consumer of the core's trace event outputs: counts per-cycle performance events, retired instructions and elapsed cycles in a bank of wrapping counters.
- Exposes the bank to software or a debug host through a simple single-cycle read/write register port.
- Sticky overflow flags can raise an interrupt.
- Sits beside the core top level and is fed directly by its registered trace event fields.

---
 rtl/perf_event_counter_bank_pkg.sv | 56 +++++
 rtl/perf_counter_cell.sv | 35 +++
 rtl/perf_event_counter_bank.sv | 120 ++++++++++++
 tb/tb_perf_event_counter_bank.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_event_counter_bank_pkg.sv
// Shared constants, control-register layout and trace-event flattening for the
// performance counter bank.
package perf_event_counter_bank_pkg;

    localparam int PERF_NUM_EVENTS = 24;
    localparam int PERF_COUNTER_W  = 32;
    localparam int PERF_INC_W      = 3;
    localparam int PERF_ADDR_W     = 5;
    localparam int PERF_NUM_CTRS   = PERF_NUM_EVENTS + 2;

    localparam int PERF_CTR_RETIRED_IDX = PERF_NUM_EVENTS;
    localparam int PERF_CTR_CYCLE_IDX   = PERF_NUM_EVENTS + 1;
    localparam int PERF_CTR_STATUS_IDX  = PERF_NUM_EVENTS + 2;
    localparam int PERF_CTR_CTRL_IDX    = 2**PERF_ADDR_W - 1;

    // Field order matches the control register bit layout (enable is bit 0).
    typedef struct packed {
        logic [PERF_NUM_CTRS-1:0] irq_mask;
        logic                     clear;
        logic                     irq_en;
        logic                     enable;
    } perf_ctrl_t;

    // Declared MSB first so that operand_stall lands on events[0].
    typedef struct packed {
        logic rs1_and_rs2_forwarding_needed;
        logic rs2_forwarding_needed;
        logic rs1_forwarding_needed;
        logic fence_op;
        logic csr_op;
        logic misaligned_op;
        logic div_op;
        logic mul_op;
        logic sc;
        logic store_op;
        logic lr;
        logic load_op;
        logic branch_or_jump_op;
        logic alu_op;
        logic div_operand_stall;
        logic ls_operand_stall;
        logic alu_operand_stall;
        logic branch_operand_stall;
        logic instruction_issued_dec;
        logic other_stall;
        logic no_instruction_stall;
        logic no_id_stall;
        logic unit_write_stall;
        logic operand_stall;
    } perf_trace_t;

    function automatic logic [PERF_NUM_EVENTS-1:0] perf_flatten_events(input perf_trace_t t);
        return t;
    endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One wrapping counter: clear beats load beats increment; ovf pulses on a carry
// out of the top bit during an increment.
module perf_counter_cell #(
    parameter int COUNTER_W = 32,
    parameter int INC_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 load,
    input  logic [COUNTER_W-1:0] load_value,
    input  logic [INC_W-1:0]     inc,
    output logic [COUNTER_W-1:0] value,
    output logic                 ovf
);

    logic [COUNTER_W:0] sum;

    assign sum = {1'b0, value} + {{(COUNTER_W + 1 - INC_W){1'b0}}, inc};
    assign ovf = enable & ~clear & ~load & sum[COUNTER_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (enable) begin
            value <= sum[COUNTER_W-1:0];
        end
    end

endmodule

// File: rtl/perf_event_counter_bank.sv
// Bank of event, retired-instruction and cycle counters with sticky overflow
// flags, an overflow interrupt and a one-cycle register access port.
module perf_event_counter_bank
    import perf_event_counter_bank_pkg::*;
#(
    parameter int NUM_EVENTS = PERF_NUM_EVENTS,
    parameter int COUNTER_W  = PERF_COUNTER_W,
    parameter int INC_W      = PERF_INC_W,
    parameter int ADDR_W     = PERF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EVENTS-1:0] events,
    input  logic [INC_W-1:0]      retire_count,
    input  logic                  reg_req,
    input  logic                  reg_we,
    input  logic [ADDR_W-1:0]     reg_addr,
    input  logic [COUNTER_W-1:0]  reg_wdata,
    output logic                  reg_ack,
    output logic [COUNTER_W-1:0]  reg_rdata,
    output logic                  overflow_irq
);

    localparam int NUM_CTRS    = NUM_EVENTS + 2;
    localparam int RETIRED_IDX = NUM_EVENTS;
    localparam int STATUS_IDX  = NUM_EVENTS + 2;
    localparam int CTRL_IDX    = 2**ADDR_W - 1;
    localparam bit MASK_FITS   = (NUM_EVENTS + 5) <= COUNTER_W;

    logic [NUM_EVENTS-1:0] ev_q;
    logic [INC_W-1:0]      rc_q;
    perf_ctrl_t            ctrl_q;
    logic [NUM_CTRS-1:0]   ovf_q;
    logic [NUM_CTRS-1:0]   ovf_pulse;
    logic [NUM_CTRS-1:0]   load;
    logic [NUM_CTRS-1:0]   w1c;
    logic [NUM_CTRS-1:0]   irq_mask;
    logic [COUNTER_W-1:0]  ctr_value [NUM_CTRS];
    logic [INC_W-1:0]      ctr_inc   [NUM_CTRS];
    logic [COUNTER_W-1:0]  rd_value;
    logic                  wr_en;

    assign wr_en    = reg_req & reg_we;
    assign w1c      = (wr_en && reg_addr == ADDR_W'(STATUS_IDX)) ? reg_wdata[NUM_CTRS-1:0] : '0;
    assign irq_mask = MASK_FITS ? ctrl_q.irq_mask : '1;

    for (genvar k = 0; k < NUM_CTRS; k++) begin : g_ctr
        if (k < NUM_EVENTS) begin : g_event
            assign ctr_inc[k] = INC_W'(ev_q[k]);
        end else if (k == RETIRED_IDX) begin : g_retired
            assign ctr_inc[k] = rc_q;
        end else begin : g_cycle
            assign ctr_inc[k] = INC_W'(1);
        end

        assign load[k] = wr_en && (reg_addr == ADDR_W'(k));

        perf_counter_cell #(
            .COUNTER_W(COUNTER_W),
            .INC_W    (INC_W)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .enable    (ctrl_q.enable),
            .clear     (ctrl_q.clear),
            .load      (load[k]),
            .load_value(reg_wdata),
            .inc       (ctr_inc[k]),
            .value     (ctr_value[k]),
            .ovf       (ovf_pulse[k])
        );
    end

    always_comb begin
        rd_value = '0;
        for (int k = 0; k < NUM_CTRS; k++) begin
            if (reg_addr == ADDR_W'(k)) rd_value = ctr_value[k];
        end
        if (reg_addr == ADDR_W'(STATUS_IDX)) begin
            rd_value = COUNTER_W'(ovf_q);
        end else if (reg_addr == ADDR_W'(CTRL_IDX)) begin
            rd_value[0] = ctrl_q.enable;
            rd_value[1] = ctrl_q.irq_en;
            if (MASK_FITS) rd_value[NUM_CTRS+2:3] = ctrl_q.irq_mask;
        end
    end

    // clear is held for exactly the cycle after the control write, so it
    // overrides any counter write issued in that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_q         <= '0;
            rc_q         <= '0;
            ctrl_q       <= '0;
            ovf_q        <= '0;
            reg_ack      <= 1'b0;
            reg_rdata    <= '0;
            overflow_irq <= 1'b0;
        end else begin
            ev_q         <= events;
            rc_q         <= retire_count;
            reg_ack      <= reg_req;
            reg_rdata    <= (reg_req && !reg_we) ? rd_value : '0;
            ctrl_q.clear <= 1'b0;
            if (wr_en && reg_addr == ADDR_W'(CTRL_IDX)) begin
                ctrl_q.enable <= reg_wdata[0];
                ctrl_q.irq_en <= reg_wdata[1];
                ctrl_q.clear  <= reg_wdata[2];
                if (MASK_FITS) ctrl_q.irq_mask <= reg_wdata[NUM_CTRS+2:3];
            end
            if (ctrl_q.clear) begin
                ovf_q <= '0;
            end else begin
                ovf_q <= (ovf_q & ~w1c) | ovf_pulse;
            end
            overflow_irq <= ctrl_q.irq_en & |(ovf_q & irq_mask);
        end
    end

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Directed bench for perf_event_counter_bank: table-driven register accesses
// plus hand-timed sequences for counting, wrap, interrupt, clear and reset.
module tb_perf_event_counter_bank;
    import perf_event_counter_bank_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] events;
    logic [2:0]  retire_count;
    logic        reg_req;
    logic        reg_we;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_ack;
    logic [31:0] reg_rdata;
    logic        overflow_irq;

    int n_cmp = 0;
    int n_bad = 0;

    perf_trace_t tr;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t rst_vecs[8];
    vec_t map_vecs[11];

    always #5 clk = ~clk;

    perf_event_counter_bank dut (
        .clk         (clk),
        .rst         (rst),
        .events      (events),
        .retire_count(retire_count),
        .reg_req     (reg_req),
        .reg_we      (reg_we),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_ack     (reg_ack),
        .reg_rdata   (reg_rdata),
        .overflow_irq(overflow_irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        reg_req   = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
    endtask

    // Leaves reg_req asserted so callers can chain back-to-back accesses.
    task automatic access(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd);
        reg_req   = 1'b1;
        reg_we    = we;
        reg_addr  = addr;
        reg_wdata = wd;
        tick();
        check("ack", {31'b0, reg_ack}, 32'd1);
        rd = reg_rdata;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] wd);
        logic [31:0] d;
        access(1'b1, addr, wd, d);
        idle();
    endtask

    task automatic rd_check(input string name, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        access(1'b0, addr, '0, d);
        idle();
        check(name, d, exp);
    endtask

    task automatic run_table(input string name, input vec_t v[], input int n);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            access(v[i].we, v[i].addr, v[i].wdata, d);
            if (!v[i].we) check($sformatf("%s[%0d]", name, i), d, v[i].exp);
        end
        idle();
    endtask

    task automatic drive_events();
        events = perf_flatten_events(tr);
    endtask

    initial begin
        logic [31:0] c1, c2, d;

        rst_vecs[0] = '{1'b0, 5'd0,  32'h0, 32'h0};
        rst_vecs[1] = '{1'b0, 5'd3,  32'h0, 32'h0};
        rst_vecs[2] = '{1'b0, 5'd23, 32'h0, 32'h0};
        rst_vecs[3] = '{1'b0, 5'd24, 32'h0, 32'h0};
        rst_vecs[4] = '{1'b0, 5'd25, 32'h0, 32'h0};
        rst_vecs[5] = '{1'b0, 5'd26, 32'h0, 32'h0};
        rst_vecs[6] = '{1'b0, 5'd31, 32'h0, 32'h0};
        rst_vecs[7] = '{1'b0, 5'd27, 32'h0, 32'h0};

        map_vecs[0]  = '{1'b1, 5'd0,  32'h11,   32'h0};
        map_vecs[1]  = '{1'b1, 5'd1,  32'h22,   32'h0};
        map_vecs[2]  = '{1'b1, 5'd2,  32'h33,   32'h0};
        map_vecs[3]  = '{1'b0, 5'd0,  32'h0,    32'h11};
        map_vecs[4]  = '{1'b0, 5'd1,  32'h0,    32'h22};
        map_vecs[5]  = '{1'b0, 5'd2,  32'h0,    32'h33};
        map_vecs[6]  = '{1'b0, 5'd31, 32'h0,    32'hB};
        map_vecs[7]  = '{1'b1, 5'd28, 32'hDEAD, 32'h0};
        map_vecs[8]  = '{1'b0, 5'd28, 32'h0,    32'h0};
        map_vecs[9]  = '{1'b0, 5'd27, 32'h0,    32'h0};
        map_vecs[10] = '{1'b0, 5'd26, 32'h0,    32'h0};

        rst          = 1'b1;
        tr           = '0;
        retire_count = '0;
        drive_events();
        idle();
        repeat (3) tick();
        check("rst_ack", {31'b0, reg_ack}, 32'd0);
        check("rst_rdata", reg_rdata, 32'd0);
        check("rst_irq", {31'b0, overflow_irq}, 32'd0);
        rst = 1'b0;
        tick();
        run_table("reset_map", rst_vecs, 8);

        // Event counting on counter 3.
        wr(5'd31, 32'h1);
        tr.no_instruction_stall = 1'b1;
        drive_events();
        repeat (5) tick();
        tr.no_instruction_stall = 1'b0;
        drive_events();
        repeat (2) tick();
        rd_check("ev3_count", 5'd3, 32'd5);
        rd_check("ev0_idle", 5'd0, 32'd0);
        access(1'b0, 5'd25, '0, c1);
        idle();
        access(1'b0, 5'd25, '0, c2);
        idle();
        check("cycle_min", {31'b0, c1 >= 32'd7}, 32'd1);
        check("cycle_rising", {31'b0, c2 > c1}, 32'd1);

        // Retired-instruction counter.
        retire_count = 3'd3;
        repeat (4) tick();
        retire_count = 3'd0;
        repeat (2) tick();
        rd_check("retired", 5'd24, 32'd12);

        // Wrap of counter 0 with interrupt enabled and unmasked.
        wr(5'd31, 32'hB);
        rd_check("ctrl_rb", 5'd31, 32'hB);
        wr(5'd0, 32'hFFFF_FFFE);
        tr.operand_stall = 1'b1;
        drive_events();
        repeat (3) tick();
        check("irq_not_yet", {31'b0, overflow_irq}, 32'd0);
        tr.operand_stall = 1'b0;
        drive_events();
        tick();
        check("irq_rise", {31'b0, overflow_irq}, 32'd1);
        rd_check("wrap_value", 5'd0, 32'd1);
        rd_check("status_set", 5'd26, 32'h1);
        wr(5'd26, 32'h2);
        rd_check("status_w0_keeps", 5'd26, 32'h1);
        wr(5'd26, 32'h1);
        rd_check("status_w1c", 5'd26, 32'h0);
        check("irq_cleared", {31'b0, overflow_irq}, 32'd0);

        // Multi-step wrap on the retired counter; bit 24 is masked off.
        wr(5'd24, 32'hFFFF_FFFE);
        retire_count = 3'd3;
        tick();
        retire_count = 3'd0;
        repeat (2) tick();
        rd_check("wrap_plus3", 5'd24, 32'd1);
        rd_check("status_bit24", 5'd26, 32'h0100_0000);
        check("irq_masked", {31'b0, overflow_irq}, 32'd0);

        // Register write beats a concurrent increment.
        tr.no_id_stall = 1'b1;
        drive_events();
        tick();
        tr.no_id_stall = 1'b0;
        drive_events();
        wr(5'd2, 32'd100);
        rd_check("write_wins", 5'd2, 32'd100);

        // Clear beats a counter write issued in the cycle it is active.
        access(1'b1, 5'd31, 32'hF, d);
        access(1'b1, 5'd5, 32'd77, d);
        idle();
        rd_check("clear_wins", 5'd5, 32'd0);
        rd_check("clear_retired", 5'd24, 32'd0);
        rd_check("clear_status", 5'd26, 32'd0);
        rd_check("clear_keeps_ctrl", 5'd31, 32'hB);
        wr(5'd6, 32'd55);
        rd_check("clear_one_shot", 5'd6, 32'd55);

        run_table("map", map_vecs, 11);
        tick();
        check("ack_drop", {31'b0, reg_ack}, 32'd0);
        check("rdata_idle", reg_rdata, 32'd0);

        // Asynchronous reset with a request in flight.
        access(1'b0, 5'd0, '0, d);
        check("pre_rst_read", d, 32'h11);
        #2;
        rst = 1'b1;
        #1;
        check("async_ack", {31'b0, reg_ack}, 32'd0);
        check("async_rdata", reg_rdata, 32'd0);
        check("async_irq", {31'b0, overflow_irq}, 32'd0);
        tick();
        check("rst_no_ack", {31'b0, reg_ack}, 32'd0);
        idle();
        rst = 1'b0;
        tick();
        check("post_rst_ack", {31'b0, reg_ack}, 32'd0);
        run_table("post_reset", rst_vecs, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
